// File: rtl/memslave_pkg.sv
// Shared definitions for the memslave64 Avalon-MM memory responder.
package memslave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Wait counter width; supports WAIT_CYCLES up to 256.
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/memslave_ram.sv
// Single-port synchronous RAM, one-cycle registered read, contents not reset.
module memslave_ram #(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned WORD_BITS = 36
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    output logic [WORD_BITS-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [WORD_BITS-1:0] mem [DEPTH];
    logic [WORD_BITS-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memslave64.sv
// 64-bit Avalon-MM memory responder storing 36-bit words, with a fixed
// waitrequest delay emulating a core-memory cycle.
module memslave64
    import memslave_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 14,
    parameter int unsigned WORD_BITS   = 36,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_address,
    input  logic        s_write,
    input  logic        s_read,
    input  logic [63:0] s_writedata,
    output logic [63:0] s_readdata,
    output logic        s_waitrequest,
    output logic        range_err,
    output logic        proto_err
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          addr_q, addr_d;
    logic [WORD_BITS-1:0] wdata_q, wdata_d;
    logic                 wr_q, wr_d;
    logic [63:0]          rdata_q, rdata_d;
    logic                 wait_q, wait_d;
    logic                 range_err_q, range_err_d;
    logic                 proto_err_q, proto_err_d;

    logic                 req_c;
    logic                 in_range_c;
    logic                 ram_we_c;
    logic [ADDR_BITS-1:0] ram_addr_c;
    logic [WORD_BITS-1:0] ram_rdata;
    logic                 unused_c;

    assign req_c      = s_read | s_write;
    assign in_range_c = (addr_q[31:ADDR_BITS] == '0);
    assign unused_c   = ^s_writedata[63:WORD_BITS];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_c) state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath next values; the RAM address follows the bus while
    // idle so read data is ready even with a single wait cycle.
    always_comb begin
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        wait_d      = 1'b1;
        range_err_d = range_err_q;
        proto_err_d = proto_err_q;
        ram_we_c    = 1'b0;
        ram_addr_c  = addr_q[ADDR_BITS-1:0];
        case (state_q)
            ST_IDLE: begin
                ram_addr_c = s_address[ADDR_BITS-1:0];
                if (req_c) begin
                    addr_d  = s_address;
                    wdata_d = s_writedata[WORD_BITS-1:0];
                    wr_d    = s_write;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    if (s_address[31:ADDR_BITS] != '0) range_err_d = 1'b1;
                    if (s_read && s_write) proto_err_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    wait_d = 1'b0;
                    if (wr_q) begin
                        ram_we_c = in_range_c & ~reset;
                    end else begin
                        rdata_d = in_range_c ? 64'(ram_rdata) : 64'd0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rdata_q     <= '0;
            wait_q      <= 1'b1;
            range_err_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            rdata_q     <= rdata_d;
            wait_q      <= wait_d;
            range_err_q <= range_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    memslave_ram #(
        .ADDR_BITS (ADDR_BITS),
        .WORD_BITS (WORD_BITS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_c),
        .addr_i  (ram_addr_c),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign s_readdata    = rdata_q;
    assign s_waitrequest = wait_q;
    assign range_err     = range_err_q;
    assign proto_err     = proto_err_q;

endmodule
